// File: rtl/bcd_serializer.sv
// Serializes parallel digits onto LINEA, MSB first, one bit per clock, with a fixed
// idle gap after each digit and a one-deep skid register to overlap acceptance.
module bcd_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             LINEA,
  output logic             frame,
  output logic             busy,
  output logic [7:0]       sent_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_valid, hold_valid_next;
  logic [CW-1:0]    bit_cnt, bit_cnt_next;
  logic [3:0]       gap_cnt, gap_cnt_next;
  logic             line_next, frame_next;
  logic [7:0]       sent_next;
  logic             xfer;
  logic             take_next;
  logic             load_en;
  logic [WIDTH-1:0] load_val;

  assign din_ready = !hold_valid && !reset;
  assign busy      = (state != ST_IDLE) || hold_valid;
  assign xfer      = din_valid && din_ready;

  always_comb begin
    state_next      = state;
    shift_next      = shift_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid;
    bit_cnt_next    = bit_cnt;
    gap_cnt_next    = gap_cnt;
    line_next       = 1'b0;
    frame_next      = 1'b0;
    sent_next       = sent_count;
    take_next       = 1'b0;
    load_en         = 1'b0;
    load_val        = din;

    case (state)
      ST_IDLE: begin
        if (xfer) begin
          load_en  = 1'b1;
          load_val = din;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt != '0) begin
          line_next    = shift_reg[WIDTH-1];
          frame_next   = 1'b1;
          shift_next   = shift_reg << 1;
          bit_cnt_next = bit_cnt - 1'b1;
        end else begin
          sent_next = sent_count + 8'd1;
          if (GAP > 0) begin
            state_next   = ST_GAP;
            gap_cnt_next = GAP_LAST;
          end else begin
            take_next = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt != 4'd0) begin
          gap_cnt_next = gap_cnt - 4'd1;
        end else begin
          take_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A digit arriving exactly when the line frees up goes straight to the shifter,
    // keeping the hold register empty whenever the machine is idle.
    if (take_next) begin
      if (hold_valid) begin
        load_en         = 1'b1;
        load_val        = hold_reg;
        hold_valid_next = 1'b0;
      end else if (xfer) begin
        load_en  = 1'b1;
        load_val = din;
      end else begin
        state_next = ST_IDLE;
      end
    end

    if (xfer && (state != ST_IDLE) && !take_next) begin
      hold_next       = din;
      hold_valid_next = 1'b1;
    end

    if (load_en) begin
      state_next   = ST_SHIFT;
      line_next    = load_val[WIDTH-1];
      frame_next   = 1'b1;
      shift_next   = load_val << 1;
      bit_cnt_next = LAST_BIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= 4'd0;
      LINEA      <= 1'b0;
      frame      <= 1'b0;
      sent_count <= 8'd0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      hold_reg   <= hold_next;
      hold_valid <= hold_valid_next;
      bit_cnt    <= bit_cnt_next;
      gap_cnt    <= gap_cnt_next;
      LINEA      <= line_next;
      frame      <= frame_next;
      sent_count <= sent_next;
    end
  end

endmodule

// File: doc/bcd_serializer.md
Name: bcd_serializer

Overview:
- Upstream feeder for the serial BCD recognizer stage.
- Accepts parallel digits over a valid/ready handshake and shifts each one onto the single-bit LINEA line, one bit per clock, MSB first.
- Inserts a fixed idle gap between digits.
- Holds one digit in a skid register so a new digit can be accepted while the current one is shifting.

Parameters:
WIDTH, 4, bits per digit (legal range 1..8)
GAP, 1, idle cycles with LINEA=0 inserted after each digit (legal range 0..15)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
din  input  WIDTH  digit to serialize
din_valid  input  1  din is valid this cycle
din_ready  output  1  block can accept din this cycle
LINEA  output  1  serial data, MSB first, registered
frame  output  1  high while LINEA carries a data bit
busy  output  1  shift in progress or digit held
sent_count  output  8  digits fully transmitted, wraps 255->0

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high.
- All outputs are registered except din_ready and busy, which are decoded from registers.
- Reset values:
  - LINEA=0, frame=0, sent_count=0.
  - State IDLE; hold register empty; bit counter 0.
  - din_ready=0 while reset is high; din_ready=1 in the first cycle after reset deasserts.
  - busy=0.
- Reset mid-operation: the in-flight digit and the held digit are discarded. LINEA=0 and frame=0 after the reset edge. No partial bits resume.
- Handshake:
  - Transfer occurs at a rising edge with din_valid=1 and din_ready=1.
  - din_ready = !hold_valid && !reset.
  - din is ignored when din_valid=0. din_valid may drop without a transfer.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Hold register is always empty here.
  - A transfer loads din directly into the shift register (bypass) and goes to SHIFT.
  - The first bit (din[WIDTH-1]) appears on LINEA with frame=1 in the cycle after the transfer edge. Latency is 1.
- SHIFT:
  - Outputs bits WIDTH-1 down to 0, one per cycle, frame=1.
  - A transfer in this state writes the hold register, so din_ready drops next cycle.
  - At the edge that ends bit 0:
    - sent_count increments.
    - If GAP>0: go to GAP.
    - If GAP=0 and hold valid: load from hold, stay in SHIFT. Back-to-back bits, no bubble.
    - Otherwise: go to IDLE.
- GAP:
  - LINEA=0, frame=0 for exactly GAP cycles.
  - A transfer here writes the hold register.
  - At the final gap edge: if hold valid, load from hold into SHIFT; otherwise go to IDLE.
- Hold-to-shift load empties the hold register, so din_ready is 1 in the cycle after the load edge.
- A new transfer can never coincide with a load from a full hold register, because din_ready=0 while hold is full.
- busy = (state != IDLE) || hold_valid.
- LINEA=0 and frame=0 whenever the state is IDLE.
- sent_count wraps from 255 to 0 with no flag.

Test Plan:
1. Single digit, WIDTH=4, GAP=1: din=4'b1001 transferred at edge 0 ->
   - LINEA 1,0,0,1 after edges 0..3 with frame=1.
   - LINEA=0, frame=0 after edge 4; sent_count=1 after edge 4.
   - busy=0 after edge 5.
2. Back-to-back: din_valid held high with 4'h9 then 4'h3 ->
   - 4'h9 transferred at edge 0 (bypass), 4'h3 transferred at edge 1 into hold; din_ready=0 after edge 1.
   - LINEA stream after edges 0..9: 1,0,0,1,0,0,0,1,1,0.
   - din_ready=1 after edge 5; sent_count=2 after edge 9.
3. GAP=0: 4'hF then 4'h0 -> eight contiguous frame=1 cycles, LINEA 1,1,1,1,0,0,0,0, no bubble.
4. Reset mid-shift: assert reset at edge 2 of digit 4'b1010 with a digit held ->
   - LINEA=0, frame=0, busy=0, sent_count=0 after edge 2.
   - din_ready=1 after reset deasserts; no stale bits are emitted afterwards.
5. Wrap: transmit 256 digits -> sent_count reads 255 after the 255th digit and 0 after the 256th.
6. Backpressure: hold full and din_valid=1 with changing din -> no transfer occurs and the held value is unchanged; the next digit serialized equals the originally held value.
